mio_bus_arbiter: RTL and testbench

Shares the single synchronous memory/IO port between the multicycle CPU and the display DMA reader. Each requester holds a level request until it receives a one-cycle ready pulse. The CPU side of the handshake replaces the CPU's `MIO_ready` input. The arbiter issues one memory access at a time, waits a fixed memory latency, registers the read data and returns it to the winning requester. The CPU has priority, with an optional starvation guard for DMA.

---
 rtl/mio_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_mio_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_arbiter.sv
// Shares one synchronous memory/IO port between the CPU and the display DMA reader.
// CPU has priority; define ARB_STARVE_GUARD_EN to let a waiting DMA win after STARVE_MAX CPU grants.
module mio_bus_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    output logic [31:0] dma_rdata,
    output logic        dma_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  grant,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
        $error("mio_bus_arbiter: MEM_LAT and STARVE_MAX must be in 1..15");
    end

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        any_req;
    logic        dma_wins;

    assign any_req = cpu_req | dma_req;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign dma_wins = dma_req && (!cpu_req || starve_cnt == 4'(STARVE_MAX));

    // Counts CPU grants that were made while DMA was already waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (state == S_IDLE && any_req) begin
            if (!dma_wins && dma_req)
                starve_cnt <= starve_cnt + 4'd1;
            else
                starve_cnt <= 4'd0;
        end
    end
`else
    assign dma_wins = dma_req && !cpu_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            grant     <= 2'b00;
            cpu_rdata <= 32'd0;
            dma_rdata <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        if (dma_wins) begin
                            grant    <= 2'b10;
                            lat_we   <= 1'b0;
                            lat_addr <= dma_addr;
                        end else begin
                            grant     <= 2'b01;
                            lat_we    <= cpu_we;
                            lat_addr  <= cpu_addr;
                            lat_wdata <= cpu_wdata;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= 4'(MEM_LAT);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        if (!lat_we) begin
                            if (grant[1])
                                dma_rdata <= mem_rdata;
                            else
                                cpu_rdata <= mem_rdata;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    grant <= 2'b00;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Every output below decodes registered state only
    assign mem_en    = (state == S_ISSUE);
    assign mem_we    = (state == S_ISSUE) && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign cpu_ready = (state == S_RESP) && grant[0];
    assign dma_ready = (state == S_RESP) && grant[1];
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter with a fixed-latency memory model (rdata = addr ^ 32'hA5A5_0000).
module tb_mio_bus_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        dma_req;
    logic [31:0] dma_addr;
    logic [31:0] dma_rdata;
    logic        dma_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  grant;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    mio_bus_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data is valid only MEM_LAT edges after the issue edge
    int          age = 0;
    logic [31:0] rd_addr = 32'd0;
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_data = 32'd0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (mem_en) begin
            age     <= 1;
            rd_addr <= mem_addr;
        end else if (age != 0 && age < 100) begin
            age <= age + 1;
        end
        if (mem_en && mem_we) begin
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
        end
    end

    assign mem_rdata = (age == MEM_LAT) ? (rd_addr ^ 32'hA5A5_0000) : 32'h0BAD_0BAD;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called in an IDLE cycle; returns in the RESP cycle with the request dropped
    task automatic cpu_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input string tag);
        int cyc;
        int en_cnt;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_req   = 1'b1;
        cyc       = 0;
        en_cnt    = 0;
        do begin
            step();
            cyc++;
            if (mem_en) en_cnt++;
        end while (!cpu_ready && cyc < 20);
        cpu_req = 1'b0;
        chk({tag, "_latency"}, 32'(cyc), 32'd4);
        chk({tag, "_mem_en_cycles"}, 32'(en_cnt), 32'd1);
    endtask

    initial begin
        int cyc;
        int tc;
        int td;
        int dma_gr;
        int n_rdy;
        int n_iss;
        int first_dma;
        int n_dma_gr;
        int n_cpu_rdy;
        int wr_before;

        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        dma_req   = 1'b0;
        dma_addr  = 32'd0;
        step();
        step();

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_ready", 32'({cpu_ready, dma_ready}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);

        reset = 1'b0;
        step();

        // CPU read of 0x40, cycle-by-cycle
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0040;
        cpu_req  = 1'b1;
        chk("rd_c_busy", 32'(busy), 32'd0);
        step();
        chk("rd_c1_mem_en", 32'(mem_en), 32'd1);
        chk("rd_c1_mem_we", 32'(mem_we), 32'd0);
        chk("rd_c1_mem_addr", mem_addr, 32'h0000_0040);
        chk("rd_c1_grant", 32'(grant), 32'd1);
        chk("rd_c1_busy", 32'(busy), 32'd1);
        step();
        chk("rd_c2_mem_en", 32'(mem_en), 32'd0);
        chk("rd_c2_ready", 32'(cpu_ready), 32'd0);
        step();
        chk("rd_c3_ready", 32'(cpu_ready), 32'd0);
        step();
        chk("rd_c4_ready", 32'(cpu_ready), 32'd1);
        chk("rd_c4_dma_ready", 32'(dma_ready), 32'd0);
        chk("rd_cpu_rdata", cpu_rdata, 32'hA5A5_0040);
        chk("rd_dma_rdata", dma_rdata, 32'd0);
        cpu_req = 1'b0;
        step();
        chk("rd_c5_ready", 32'(cpu_ready), 32'd0);
        chk("rd_c5_busy", 32'(busy), 32'd0);
        chk("rd_c5_grant", 32'(grant), 32'd0);

        // CPU write
        wr_before = wr_cnt;
        cpu_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr");
        chk("wr_pulses", 32'(wr_cnt - wr_before), 32'd1);
        chk("wr_addr", wr_addr, 32'h0000_0010);
        chk("wr_data", wr_data, 32'hDEAD_BEEF);
        chk("wr_cpu_rdata_kept", cpu_rdata, 32'hA5A5_0040);
        step();

        // Simultaneous CPU and DMA requests
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0200;
        dma_addr = 32'h0000_0300;
        cpu_req  = 1'b1;
        dma_req  = 1'b1;
        step();
        chk("sim_first_grant", 32'(grant), 32'd1);
        cyc = 1; tc = 0; td = 0; dma_gr = 0;
        while ((tc == 0 || td == 0) && cyc < 40) begin
            if (cpu_ready && tc == 0) begin tc = cyc; cpu_req = 1'b0; end
            if (dma_ready && td == 0) begin td = cyc; dma_req = 1'b0; end
            if (mem_en && grant == 2'b10) dma_gr = 1;
            if (tc == 0 || td == 0) begin step(); cyc++; end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        chk("sim_cpu_ready_cycle", 32'(tc), 32'd4);
        chk("sim_dma_after_cpu", 32'(td - tc), 32'(MEM_LAT + 3));
        chk("sim_dma_granted", 32'(dma_gr), 32'd1);
        chk("sim_cpu_rdata", cpu_rdata, 32'hA5A5_0200);
        chk("sim_dma_rdata", dma_rdata, 32'hA5A5_0300);
        step();

        // Starvation: CPU requests continuously while DMA is held
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0500;
        dma_addr = 32'h0000_0600;
        cpu_req  = 1'b1;
        dma_req  = 1'b1;
        n_rdy = 0; n_iss = 0; first_dma = -1; n_dma_gr = 0; n_cpu_rdy = 0; cyc = 0;
        while (n_rdy < 50 && cyc < 400) begin
            step();
            cyc++;
            if (mem_en) begin
                if (grant == 2'b10) begin
                    n_dma_gr++;
                    if (first_dma < 0) first_dma = n_iss;
                end
                n_iss++;
            end
            if (dma_ready) dma_req = 1'b0;
            if (cpu_ready) n_cpu_rdy++;
            if (cpu_ready || dma_ready) n_rdy++;
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        chk("starve_accesses", 32'(n_rdy), 32'd50);
`ifdef ARB_STARVE_GUARD_EN
        chk("starve_cpu_grants_before_dma", 32'(first_dma), 32'(STARVE_MAX));
        chk("starve_dma_grants", 32'(n_dma_gr), 32'd1);
`else
        chk("starve_dma_grants", 32'(n_dma_gr), 32'd0);
        chk("starve_cpu_completions", 32'(n_cpu_rdy), 32'd50);
`endif
        step();

        // Reset while a CPU read is in WAIT
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0080;
        cpu_req  = 1'b1;
        step();
        step();
        chk("rw_in_wait_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_grant", 32'(grant), 32'd0);
        chk("rw_mem_en", 32'(mem_en), 32'd0);
        chk("rw_mem_addr", mem_addr, 32'd0);
        chk("rw_cpu_rdata", cpu_rdata, 32'd0);
        chk("rw_dma_rdata", dma_rdata, 32'd0);
        cpu_req = 1'b0;
        step();
        reset = 1'b0;
        tc = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (cpu_ready) tc++;
        end
        chk("rw_no_cpu_ready", 32'(tc), 32'd0);
        chk("rw_idle", 32'(busy), 32'd0);

        dma_addr = 32'h0000_1234;
        dma_req  = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!dma_ready && cyc < 20);
        dma_req = 1'b0;
        chk("rw_dma_latency", 32'(cyc), 32'd4);
        chk("rw_dma_rdata", dma_rdata, 32'hA5A5_1234);
        chk("rw_cpu_rdata_after", cpu_rdata, 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
